// File: rtl/tic_tac_toe_autoplayer.sv
// Player-2 agent: thinks THINK_CYCLES, pulses one button PRESS_CYCLES, then waits up to ACK_TIMEOUT for its LED.
// No flow control: enable low or game-over aborts any move on the next edge.
module tic_tac_toe_autoplayer #(
  parameter int THINK_CYCLES = 4,
  parameter int PRESS_CYCLES = 2,
  parameter int ACK_TIMEOUT  = 16
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       enable,
  input  logic       p2_turn,
  input  logic       p1_win,
  input  logic       p2_win,
  input  logic       grid_full,
  input  logic [8:0] led,
  output logic [8:0] button,
  output logic [8:0] own_cells,
  output logic       busy,
  output logic       err
);

  localparam int CMAX = (ACK_TIMEOUT > THINK_CYCLES) ?
                        ((ACK_TIMEOUT > PRESS_CYCLES) ? ACK_TIMEOUT : PRESS_CYCLES) :
                        ((THINK_CYCLES > PRESS_CYCLES) ? THINK_CYCLES : PRESS_CYCLES);
  localparam int CW = $clog2(CMAX + 1);

  typedef enum logic [1:0] {IDLE, THINK, PRESS, WAIT_ACK} state_t;

  state_t          state, state_nx;
  logic [CW-1:0]   cnt, cnt_nx;
  logic [8:0]      sel_q, sel_nx, own_nx;
  logic            armed, armed_nx, err_nx, over, abort;

  // Lines in scan order: abc, def, ghi, adg, beh, cfi, aei, ceg.
  function automatic logic [8:0] line_mask(input int k);
    case (k)
      0:       line_mask = 9'h007;
      1:       line_mask = 9'h038;
      2:       line_mask = 9'h1C0;
      3:       line_mask = 9'h049;
      4:       line_mask = 9'h092;
      5:       line_mask = 9'h124;
      6:       line_mask = 9'h111;
      default: line_mask = 9'h054;
    endcase
  endfunction

  function automatic logic [8:0] pick_cell(input logic [8:0] brd, input logic [8:0] own);
    logic [8:0] opp, emp, m, res, cand;
    logic       found;
    opp   = brd & ~own;
    emp   = ~brd;
    res   = '0;
    found = 1'b0;
    for (int k = 0; k < 8; k++) begin
      m = line_mask(k);
      if (!found && $countones(own & m) == 2 && $countones(emp & m) == 1) begin
        res   = emp & m;
        found = 1'b1;
      end
    end
    for (int k = 0; k < 8; k++) begin
      m = line_mask(k);
      if (!found && $countones(opp & m) == 2 && $countones(emp & m) == 1) begin
        res   = emp & m;
        found = 1'b1;
      end
    end
    if (!found && emp[4]) begin
      res   = 9'h010;
      found = 1'b1;
    end
    // Corners and edges are listed in ascending bit order, so "first empty" is the lowest set bit.
    cand = emp & 9'h145;
    if (!found && cand != '0) begin
      res   = cand & (~cand + 9'd1);
      found = 1'b1;
    end
    cand = emp & 9'h0AA;
    if (!found && cand != '0) begin
      res = cand & (~cand + 9'd1);
    end
    return res;
  endfunction

  assign over  = p1_win | p2_win | grid_full;
  assign abort = !enable || over;

  always_comb begin
    state_nx = state;
    sel_nx   = sel_q;
    own_nx   = own_cells;
    armed_nx = armed;
    err_nx   = err;
    case (state)
      IDLE: begin
        if (!p2_turn) armed_nx = 1'b1;
        if (enable && p2_turn && armed && !over && led != 9'h1FF) state_nx = THINK;
      end
      THINK: begin
        if (abort) state_nx = IDLE;
        else if (cnt == CW'(THINK_CYCLES - 1)) begin
          sel_nx   = pick_cell(led, own_cells);
          state_nx = PRESS;
        end
      end
      PRESS: begin
        if (abort) state_nx = IDLE;
        else if (cnt == CW'(PRESS_CYCLES - 1)) state_nx = WAIT_ACK;
      end
      default: begin
        if (abort) state_nx = IDLE;
        else if ((led & sel_q) != '0) begin
          own_nx   = own_cells | sel_q;
          armed_nx = 1'b0;
          state_nx = IDLE;
        end else if (cnt == CW'(ACK_TIMEOUT - 1)) begin
          // Disarm on timeout too, so a stuck board does not trigger back-to-back presses.
          err_nx   = 1'b1;
          armed_nx = 1'b0;
          state_nx = IDLE;
        end
      end
    endcase
    if (led == '0) own_nx = '0;
    if (state_nx == state && state != IDLE) cnt_nx = cnt + CW'(1);
    else cnt_nx = '0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      cnt       <= '0;
      sel_q     <= '0;
      own_cells <= '0;
      busy      <= 1'b0;
      err       <= 1'b0;
      armed     <= 1'b1;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      sel_q     <= sel_nx;
      own_cells <= own_nx;
      busy      <= (state_nx != IDLE);
      err       <= err_nx;
      armed     <= armed_nx;
    end
  end

  always_comb begin
    button = '0;
    if (state == PRESS) button = sel_q;
  end

endmodule
